seq_chunk_adder: RTL and testbench

//   Multi-cycle, parametrised adder/subtractor. Adds CHUNK bits per cycle, LSB chunk first,

---
 rtl/adder_pkg.sv | 10 +
 rtl/chunk_ripple_adder.sv | 20 ++
 rtl/seq_chunk_adder.sv | 114 +++++++++++
 tb/tb_seq_chunk_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: FSM states and width helper shared by seq_chunk_adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder: combinational ripple of CHUNK full adders
module chunk_ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per cycle through one shared ripple chain
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d, sum_q, sum_d;
  logic carry_q, carry_d, msb_q, msb_d, out_valid_q, out_valid_d;
  logic cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] s;
  logic co, cm, last;
  assign last = idx_q == IW'(NCHUNK - 1);
  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chain (
    .a    (op_a_q[idx_q*CHUNK +: CHUNK]),
    .b    (op_b_q[idx_q*CHUNK +: CHUNK]),
    .cin  (carry_q),
    .s    (s),
    .cout (co),
    .c_msb(cm)
  );
  // capture operands in IDLE, ripple one chunk per RUN cycle, load then present result in DONE
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    res_d = res_q;
    carry_d = carry_q;
    msb_d = msb_q;
    out_valid_d = out_valid_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      op_a_d = a;
      op_b_d = sub ? ~b : b;
      carry_d = sub ? ~cin : cin;
      idx_d = '0;
      state_d = RUN;
    end
    if (state_q == RUN) begin
      res_d[idx_q*CHUNK +: CHUNK] = s;
      carry_d = co;
      msb_d = cm;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end
    if (state_q == DONE && !out_valid_q) begin
      sum_d = res_q;
      cout_d = carry_q;
      ovf_d = msb_q ^ carry_q;
      out_valid_d = 1'b1;
    end
    if (state_q == DONE && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      msb_q <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      res_q <= res_d;
      carry_q <= carry_d;
      msb_q <= msb_d;
      out_valid_q <= out_valid_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: randomized self-checking bench against an arithmetic reference model
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] iv = '0, ordy = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic cin_i = 1'b0, sub_i = 1'b0;
  logic [2:0] ir, ov, co, of;
  logic [7:0] s8;
  logic [31:0] sa, sb;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .sub(sub_i), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .ovf(of[0])
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u32w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_i), .b(b_i),
    .cin(cin_i), .sub(sub_i), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sa), .cout(co[1]), .ovf(of[1])
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_i), .b(b_i),
    .cin(cin_i), .sub(sub_i), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sb), .cout(co[2]), .ovf(of[2])
  );
  // reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow
  function automatic void model(input int w, input longint a, input longint b, input bit c, input bit s,
                                output longint r, output bit rc, output bit ro);
    longint m, h, xa, xb, ci, u, sg;
    m = longint'(1) << w;
    h = m / 2;
    ci = longint'(c);
    xa = a >= h ? a - m : a;
    xb = b >= h ? b - m : b;
    u = s ? a - b - ci : a + b + ci;
    sg = s ? xa - xb - ci : xa + xb + ci;
    r = u & (m - 1);
    rc = s ? u >= 0 : u >= m;
    ro = sg < -h || sg >= h;
  endfunction
  task automatic run(input int k, input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                     output logic [31:0] r, output logic rc, output logic ro, output int lat);
    a_i = a;
    b_i = b;
    cin_i = c;
    sub_i = s;
    iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = k == 0 ? {24'd0, s8} : k == 1 ? sa : sb;
    rc = co[k];
    ro = of[k];
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask
  task automatic test_reset;
    #12;
    n_checks++;
    if (ir !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready got %b want 111", ir); end
    n_checks++;
    if ({ov, co, of} !== 9'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {ov, co, of}); end
    n_checks++;
    if ({s8, sa, sb} !== 72'd0) begin n_fail++; $display("FAIL reset_sum got %h want 0", {s8, sa, sb}); end
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ir, ov} !== 6'b111_000) begin n_fail++; $display("FAIL post_reset got %b want 111000", {ir, ov}); end
  endtask
  task automatic test_add;
    logic [31:0] r, xa, xb;
    logic rc, ro, xc;
    int lat;
    longint er;
    bit ec, eo;
    for (int i = 0; i < 19; i++) begin
      xa = $urandom_range(255);
      xb = $urandom_range(255);
      xc = 1'($urandom_range(1));
      if (i == 0) begin xa = 'h01; xb = 'h01; xc = 0; end
      if (i == 1) begin xa = 'hFF; xb = 'hFF; xc = 0; end
      if (i == 2) begin xa = 'h7F; xb = 'h01; xc = 0; end
      model(8, xa, xb, xc, 1'b0, er, ec, eo);
      run(0, xa, xb, xc, 1'b0, r, rc, ro, lat);
      n_checks++;
      if (r !== er[31:0]) begin n_fail++; $display("FAIL add_sum %h+%h+%b got %h want %h", xa, xb, xc, r, er[31:0]); end
      n_checks++;
      if (rc !== ec) begin n_fail++; $display("FAIL add_cout %h+%h+%b got %b want %b", xa, xb, xc, rc, ec); end
      n_checks++;
      if (ro !== eo) begin n_fail++; $display("FAIL add_ovf %h+%h+%b got %b want %b", xa, xb, xc, ro, eo); end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", lat); end
    end
  endtask
  task automatic test_sub;
    logic [31:0] r, xa, xb;
    logic rc, ro, xc;
    int lat;
    longint er;
    bit ec, eo;
    for (int i = 0; i < 18; i++) begin
      xa = $urandom_range(255);
      xb = $urandom_range(255);
      xc = 1'($urandom_range(1));
      if (i == 0) begin xa = 'h05; xb = 'h07; xc = 0; end
      if (i == 1) begin xa = 'h80; xb = 'h01; xc = 0; end
      model(8, xa, xb, xc, 1'b1, er, ec, eo);
      run(0, xa, xb, xc, 1'b1, r, rc, ro, lat);
      n_checks++;
      if (r !== er[31:0]) begin n_fail++; $display("FAIL sub_sum %h-%h-%b got %h want %h", xa, xb, xc, r, er[31:0]); end
      n_checks++;
      if (rc !== ec) begin n_fail++; $display("FAIL sub_cout %h-%h-%b got %b want %b", xa, xb, xc, rc, ec); end
      n_checks++;
      if (ro !== eo) begin n_fail++; $display("FAIL sub_ovf %h-%h-%b got %b want %b", xa, xb, xc, ro, eo); end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL sub_latency got %0d want 3", lat); end
    end
  endtask
  task automatic test_stall;
    logic [7:0] r0;
    logic c0, o0;
    int lat;
    longint er;
    bit ec, eo;
    model(8, 'h3C, 'h41, 1'b1, 1'b0, er, ec, eo);
    a_i = 'h3C;
    b_i = 'h41;
    cin_i = 1'b1;
    sub_i = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (!ov[0] && lat < 40) begin
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    r0 = s8;
    c0 = co[0];
    o0 = of[0];
    n_checks++;
    if ({r0, c0, o0} !== {er[7:0], ec, eo}) begin n_fail++; $display("FAIL stall_result got %h/%b/%b want %h/%b/%b", r0, c0, o0, er[7:0], ec, eo); end
    for (int j = 0; j < 5; j++) begin
      a_i = $urandom;
      b_i = $urandom;
      sub_i = 1'($urandom_range(1));
      cin_i = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      n_checks++;
      if ({ov[0], ir[0]} !== 2'b10) begin n_fail++; $display("FAIL stall_hs cycle %0d got %b want 10", j, {ov[0], ir[0]}); end
      n_checks++;
      if ({s8, co[0], of[0]} !== {r0, c0, o0}) begin n_fail++; $display("FAIL stall_hold cycle %0d got %h want %h", j, {s8, co[0], of[0]}, {r0, c0, o0}); end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    n_checks++;
    if ({ov[0], ir[0]} !== 2'b01) begin n_fail++; $display("FAIL stall_release got %b want 01", {ov[0], ir[0]}); end
    n_checks++;
    if ({s8, co[0], of[0]} !== {r0, c0, o0}) begin n_fail++; $display("FAIL stall_keep got %h want %h", {s8, co[0], of[0]}, {r0, c0, o0}); end
  endtask
  task automatic test_reset_mid_run;
    logic [31:0] r;
    logic rc, ro;
    int lat;
    bit seen;
    run(0, 'h21, 'h13, 1'b0, 1'b0, r, rc, ro, lat);
    n_checks++;
    if (r !== 32'h34) begin n_fail++; $display("FAIL pre_abort_sum got %h want 34", r); end
    a_i = 'h55;
    b_i = 'h66;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s8, co[0], of[0]} !== 10'd0) begin n_fail++; $display("FAIL abort_outputs got %h want 0", {s8, co[0], of[0]}); end
    n_checks++;
    if ({ov[0], ir[0]} !== 2'b01) begin n_fail++; $display("FAIL abort_hs got %b want 01", {ov[0], ir[0]}); end
    #2 rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (ov[0]) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid got %b want 0", seen); end
    run(0, 'h10, 'h22, 1'b0, 1'b0, r, rc, ro, lat);
    n_checks++;
    if (r !== 32'h32) begin n_fail++; $display("FAIL after_abort_sum got %h want 32", r); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL after_abort_latency got %0d want 3", lat); end
  endtask
  task automatic test_wide;
    logic [31:0] r, xa, xb;
    logic rc, ro, xc, xs;
    int lat, el;
    longint er;
    bit ec, eo;
    for (int k = 1; k < 3; k++) begin
      el = k == 1 ? 2 : 5;
      for (int i = 0; i < 6; i++) begin
        xa = $urandom;
        xb = $urandom;
        xc = 1'($urandom_range(1));
        xs = 1'($urandom_range(1));
        if (i == 0) begin xa = 32'hFFFF_FFFF; xb = 0; xc = 1; xs = 0; end
        model(32, xa, xb, xc, xs, er, ec, eo);
        run(k, xa, xb, xc, xs, r, rc, ro, lat);
        n_checks++;
        if (r !== er[31:0]) begin n_fail++; $display("FAIL wide%0d_sum got %h want %h", k, r, er[31:0]); end
        n_checks++;
        if ({rc, ro} !== {ec, eo}) begin n_fail++; $display("FAIL wide%0d_flags got %b want %b", k, {rc, ro}, {ec, eo}); end
        n_checks++;
        if (lat !== el) begin n_fail++; $display("FAIL wide%0d_latency got %0d want %0d", k, lat, el); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_stall;
    test_reset_mid_run;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
